// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: NOP encoding, reset vector,
// fetch FSM encodings and the IF/ID payload layout.
package fetch_stage_pkg;

  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{instr: NOP, pc_plus4: 32'h0, valid: 1'b0};

  // Low two bits of a jump target are don't-care; force word alignment.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// 65-bit IF/ID pipeline register with bubble/load/hold control; also serves as
// the one-entry skid buffer.
module ifid_reg
  import fetch_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset lives in the sensitivity list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q <= BUBBLE;
    else if (bubble) q <= BUBBLE;
    else if (load)   q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: PC ownership, imem req/ack handshake, IF/ID
// register, one-entry skid buffer for stalls and wrong-path squash on redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_stage_if.master        imem,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic [31:0]          instr,
  output logic [31:0]          pc_plus4,
  output logic                 instr_valid
);

  logic [1:0]  state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] req_addr, req_addr_nx;
  logic [31:0] seq_pc, target;
  logic        fetching, ack_hit;
  logic        ifid_load, ifid_bubble, skid_load, skid_bubble;
  ifid_t       fetched, ifid_d, ifid_q, skid_q;

  assign fetching  = (state == FETCH) || (state == DRAIN);
  assign ack_hit   = fetching && imem.ack;
  assign seq_pc    = req_addr + 32'd4;
  assign target    = word_align(redirect_pc);
  assign fetched   = '{instr: imem.rdata, pc_plus4: seq_pc, valid: 1'b1};
  assign ifid_d    = (state == HOLD) ? skid_q : fetched;

  assign imem.req  = fetching;
  assign imem.addr = req_addr;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    req_addr_nx = req_addr;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    skid_load   = 1'b0;
    skid_bubble = 1'b0;
    case (state)
      IDLE: begin
        state_nx    = FETCH;
        req_addr_nx = pc;
      end
      FETCH: begin
        if (redirect_valid) begin
          ifid_bubble = 1'b1;
          skid_bubble = 1'b1;
          pc_nx       = target;
          if (ack_hit) req_addr_nx = target;
          else         state_nx    = DRAIN;  // address must stay put until ack
        end else if (ack_hit) begin
          pc_nx = seq_pc;
          if (stall) begin
            skid_load = 1'b1;
            state_nx  = HOLD;
          end else begin
            ifid_load   = 1'b1;
            req_addr_nx = seq_pc;
          end
        end else if (!stall) begin
          ifid_bubble = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          ifid_bubble = 1'b1;
          skid_bubble = 1'b1;
          pc_nx       = target;
          req_addr_nx = target;
          state_nx    = FETCH;
        end else if (!stall) begin
          ifid_load   = 1'b1;
          skid_bubble = 1'b1;
          req_addr_nx = pc;
          state_nx    = FETCH;
        end
      end
      DRAIN: begin
        ifid_bubble = 1'b1;
        if (redirect_valid) pc_nx = target;
        if (ack_hit) begin
          req_addr_nx = redirect_valid ? target : pc;
          state_nx    = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      req_addr <= req_addr_nx;
    end
  end

  ifid_reg u_ifid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  ifid_reg u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (skid_load),
    .bubble (skid_bubble),
    .d      (fetched),
    .q      (skid_q)
  );

  assign instr       = ifid_q.instr;
  assign pc_plus4    = ifid_q.pc_plus4;
  assign instr_valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected IF/ID
// contents; a negedge monitor pops and compares whenever a new instruction lands.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] instr, pc_plus4;
  logic        instr_valid;

  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (bus),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr          (instr),
    .pc_plus4       (pc_plus4),
    .instr_valid    (instr_valid)
  );

  // Memory model: ack after mem_lat waiting cycles; data tags the address.
  int mem_lat = 0;
  int wait_cnt;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {8'hC0, a[23:0]};
  endfunction

  assign bus.ack   = bus.req && (wait_cnt >= mem_lat);
  assign bus.rdata = word(bus.addr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wait_cnt <= 0;
    else if (!bus.req || bus.ack) wait_cnt <= 0;
    else                         wait_cnt <= wait_cnt + 1;
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p);
    exp_t e;
    e.instr = i;
    e.pc4   = p;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // IF/ID holds a fresh entry whenever stall was low at the last edge.
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (!instr_valid) begin
        check("nop_when_invalid", instr, NOP);
      end else if (!prev_stall) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_instr: got %h pc_plus4 %h, expected none", instr, pc_plus4);
        end else begin
          e = sbq.pop_front();
          check("instr", instr, e.instr);
          check("pc_plus4", pc_plus4, e.pc4);
        end
      end
    end
    prev_stall = stall;
  end

  initial begin
    #20000;
    n_err++;
    $display("FAIL timeout: got no finish, expected finish before 20000");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    // Sequential zero-wait fetch from the reset vector.
    push(32'hC000_0000, 32'h0000_0004);
    push(32'hC000_0004, 32'h0000_0008);
    push(32'hC000_0008, 32'h0000_000C);
    push(32'hC000_000C, 32'h0000_0010);
    #12;
    check("rst_req", {31'h0, bus.req}, 32'h0);
    check("rst_addr", bus.addr, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc4", pc_plus4, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("addr_seq", bus.addr, 32'h0000_0010);
    check("req_seq", {31'h0, bus.req}, 32'h1);

    // Stall on the ack of 0x10: word goes to skid, IF/ID keeps 0x0C word.
    stall = 1'b1;
    push(32'hC000_0010, 32'h0000_0014);
    tick();
    check("hold_req", {31'h0, bus.req}, 32'h0);
    check("hold_instr", instr, 32'hC000_000C);
    check("hold_valid", {31'h0, instr_valid}, 32'h1);
    tick();
    tick();
    check("hold_req_late", {31'h0, bus.req}, 32'h0);
    stall = 1'b0;
    tick();
    check("resume_addr", bus.addr, 32'h0000_0014);

    // Slow memory; redirect while 0x14 is outstanding.
    mem_lat = 2;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    check("drain_addr0", bus.addr, 32'h0000_0014);
    check("drain_req", {31'h0, bus.req}, 32'h1);
    check("drain_valid0", {31'h0, instr_valid}, 32'h0);
    tick();
    check("drain_addr1", bus.addr, 32'h0000_0014);
    check("drain_valid1", {31'h0, instr_valid}, 32'h0);
    tick();
    check("redir_addr", bus.addr, 32'h0000_0200);
    check("redir_valid", {31'h0, instr_valid}, 32'h0);
    mem_lat = 0;
    push(32'hC000_0200, 32'h0000_0204);
    push(32'hC000_0204, 32'h0000_0208);
    tick();
    tick();

    // Redirect and stall together while in HOLD.
    stall = 1'b1;
    tick();
    check("hold2_req", {31'h0, bus.req}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0400;
    tick();
    redirect_valid = 1'b0;
    stall = 1'b0;
    check("hr_valid", {31'h0, instr_valid}, 32'h0);
    check("hr_instr", instr, 32'h0);
    check("hr_addr", bus.addr, 32'h0000_0400);
    check("hr_req", {31'h0, bus.req}, 32'h1);
    push(32'hC000_0400, 32'h0000_0404);
    tick();

    // Redirect to the top of the address space; PC+4 wraps to zero.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    check("wrap_addr", bus.addr, 32'hFFFF_FFFC);
    check("wrap_valid", {31'h0, instr_valid}, 32'h0);
    push(32'hC0FF_FFFC, 32'h0000_0000);
    push(32'hC000_0000, 32'h0000_0004);
    tick();
    check("wrap_next_addr", bus.addr, 32'h0000_0000);
    check("wrap_pc4", pc_plus4, 32'h0000_0000);
    tick();

    // Reset asserted in the middle of a DRAIN.
    mem_lat = 3;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0800;
    tick();
    redirect_valid = 1'b0;
    check("drain2_addr", bus.addr, 32'h0000_0004);
    tick();
    check("drain2_req", {31'h0, bus.req}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_req", {31'h0, bus.req}, 32'h0);
    check("arst_addr", bus.addr, 32'h0);
    check("arst_instr", instr, 32'h0);
    check("arst_pc4", pc_plus4, 32'h0);
    check("arst_valid", {31'h0, instr_valid}, 32'h0);
    mem_lat = 0;
    push(32'hC000_0000, 32'h0000_0004);
    push(32'hC000_0004, 32'h0000_0008);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
    check("scoreboard_left", sbq.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
